// File: rtl/hex_sseg_mux.sv
// Multiplexed hex seven-segment driver: prescaled digit scan, shadowed display data,
// active-low registered anode/cathode outputs. Optional leading-zero blanking via `SSEG_LZ_SUPPRESS_EN.
module hex_sseg_mux #(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned PRESC_W  = 18
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] hex_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank_in,
    output logic [N_DIGITS-1:0]   an,
    output logic [7:0]            sseg,
    output logic                  frame_start
);

    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned HEX_W = 4 * N_DIGITS;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    logic [PRESC_W-1:0]  cnt_q,   cnt_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;
    logic [HEX_W-1:0]    hex_q,   hex_d;
    logic [N_DIGITS-1:0] dp_q,    dp_d;
    logic [N_DIGITS-1:0] blank_q, blank_d;
    logic [N_DIGITS-1:0] an_q,    an_d;
    logic [7:0]          sseg_q,  sseg_d;
    logic                fs_q,    fs_d;

    logic                tick_c;
    logic [N_DIGITS-1:0] dark_vec_c;
    logic [3:0]          sel_hex_c;
    logic                sel_dp_c;
    logic                sel_dark_c;

    // Active-high a..g patterns.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign tick_c = &cnt_q;

`ifdef SSEG_LZ_SUPPRESS_EN
    logic [N_DIGITS-1:0] lz_c;

    // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        lz_c = '0;
        lz_c[N_DIGITS-1] = (hex_q[HEX_W-1 -: 4] == 4'h0);
        for (int i = int'(N_DIGITS) - 2; i >= 0; i--) begin
            lz_c[i] = lz_c[i+1] && (hex_q[4*i +: 4] == 4'h0);
        end
        lz_c[0] = 1'b0;
    end

    assign dark_vec_c = blank_q | lz_c;
`else
    assign dark_vec_c = blank_q;
`endif

    // Pick the shadow data of the digit currently being scanned.
    always_comb begin
        sel_hex_c  = hex_q[3:0];
        sel_dp_c   = dp_q[0];
        sel_dark_c = dark_vec_c[0];
        for (int i = 1; i < int'(N_DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_hex_c  = hex_q[4*i +: 4];
                sel_dp_c   = dp_q[i];
                sel_dark_c = dark_vec_c[i];
            end
        end
    end

    always_comb begin
        cnt_d   = cnt_q + PRESC_W'(1);
        idx_d   = idx_q;
        fs_d    = 1'b0;
        hex_d   = hex_q;
        dp_d    = dp_q;
        blank_d = blank_q;
        an_d    = '1;
        sseg_d  = 8'hFF;

        if (tick_c) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            fs_d  = (idx_q == IDX_LAST);
        end

        if (load) begin
            hex_d   = hex_in;
            dp_d    = dp_in;
            blank_d = blank_in;
        end

        if (!sel_dark_c) begin
            an_d   = ~(N_DIGITS'(1) << idx_q);
            sseg_d = {~sel_dp_c, ~hex_to_seg(sel_hex_c)};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            fs_q    <= 1'b0;
            hex_q   <= '0;
            dp_q    <= '0;
            blank_q <= '1;
            an_q    <= '1;
            sseg_q  <= 8'hFF;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            fs_q    <= fs_d;
            hex_q   <= hex_d;
            dp_q    <= dp_d;
            blank_q <= blank_d;
            an_q    <= an_d;
            sseg_q  <= sseg_d;
        end
    end

    assign an          = an_q;
    assign sseg        = sseg_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_hex_sseg_mux.sv
// Bench for hex_sseg_mux (N_DIGITS=4, PRESC_W=2): per-cycle reference model plus directed
// literal checks; honours `SSEG_LZ_SUPPRESS_EN when the build defines it.
module tb_hex_sseg_mux;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] hex_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic        frame_start;

    int vectors = 0;
    int miscompares = 0;

    hex_sseg_mux #(.N_DIGITS(4), .PRESC_W(2)) dut (
        .clk(clk), .reset(reset), .load(load), .hex_in(hex_in), .dp_in(dp_in),
        .blank_in(blank_in), .an(an), .sseg(sseg), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    // Display word {an, sseg} for digit d given shadow contents.
    function automatic logic [11:0] disp(int d, logic [15:0] h, logic [3:0] dpv, logic [3:0] bl);
        logic       dark;
        logic       lz;
        logic [3:0] a;
        dark = bl[d];
        lz   = 1'b0;
`ifdef SSEG_LZ_SUPPRESS_EN
        if (d != 0) begin
            lz = 1'b1;
            for (int j = d; j < 4; j++) if (h[4*j +: 4] != 4'h0) lz = 1'b0;
        end
`endif
        if (dark || lz) return {4'hF, 8'hFF};
        a    = 4'hF;
        a[d] = 1'b0;
        return {a, ~dpv[d], ~seg_tab[h[4*d +: 4]][6:0]};
    endfunction

    // Model: e = edges since reset release; digit scanned after e edges is (e/4)%4.
    int          e = 0;
    int          m_d = 0;
    logic [15:0] m_hex = '0;
    logic [3:0]  m_dp = '0;
    logic [3:0]  m_blank = 4'hF;
    logic [3:0]  exp_an = 4'hF;
    logic [7:0]  exp_sseg = 8'hFF;
    logic        exp_fs = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            e = 0; m_hex = '0; m_dp = '0; m_blank = 4'hF;
            exp_an = 4'hF; exp_sseg = 8'hFF; exp_fs = 1'b0;
        end else begin
            m_d = (e / 4) % 4;
            {exp_an, exp_sseg} = disp(m_d, m_hex, m_dp, m_blank);
            exp_fs = ((e + 1) % 16 == 0);
            if (load) begin
                m_hex = hex_in; m_dp = dp_in; m_blank = blank_in;
            end
            e++;
        end
    end

    always @(negedge clk) begin
        vectors++;
        if ({an, sseg, frame_start} !== {exp_an, exp_sseg, exp_fs}) begin
            miscompares++;
            $display("FAIL model e=%0d: an=%b sseg=%h fs=%b, expected an=%b sseg=%h fs=%b",
                     e, an, sseg, frame_start, exp_an, exp_sseg, exp_fs);
        end
    end

    task automatic lit(string name, logic [3:0] ea, logic [7:0] es);
        vectors++;
        if (an !== ea || sseg !== es) begin
            miscompares++;
            $display("FAIL %s: an=%b sseg=%h, expected an=%b sseg=%h", name, an, sseg, ea, es);
        end
    endtask

    task automatic lit_fs(string name, logic ef);
        vectors++;
        if (frame_start !== ef) begin
            miscompares++;
            $display("FAIL %s: frame_start=%b, expected %b", name, frame_start, ef);
        end
    endtask

    task automatic goto(int k);
        while (e < k) @(negedge clk);
    endtask

    task automatic set_in(logic [15:0] h, logic [3:0] d, logic [3:0] b);
        hex_in = h; dp_in = d; blank_in = b; load = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        lit("reset_dark", 4'hF, 8'hFF);
        lit_fs("reset_fs", 1'b0);
        set_in(16'h1234, 4'b0000, 4'b0000);
        reset = 1'b0;
        goto(1);  load = 1'b0;
        lit("preload_dark", 4'hF, 8'hFF);
        goto(2);  lit("d0_1234", 4'b1110, 8'h99);
        goto(5);  lit("d1_1234", 4'b1101, 8'hB0);
        goto(9);  lit("d2_1234", 4'b1011, 8'hA4);
        goto(13); lit("d3_1234", 4'b0111, 8'hF9);
        goto(16); lit_fs("fs_first_wrap", 1'b1);
        goto(17); lit_fs("fs_one_wide", 1'b0);
        lit("d0_again", 4'b1110, 8'h99);

        set_in(16'h8888, 4'b0100, 4'b0000);
        goto(18); load = 1'b0;
        goto(32); lit_fs("fs_second_wrap", 1'b1);
        goto(33); lit("d0_8888", 4'b1110, 8'h80);
        goto(41); lit("d2_8888_dp", 4'b1011, 8'h00);
        goto(45); lit("d3_8888", 4'b0111, 8'h80);

        goto(48); set_in(16'h8888, 4'b0100, 4'b1000);
        goto(49); load = 1'b0;
        goto(50); lit("d0_blank3", 4'b1110, 8'h80);
        goto(57); lit("d2_blank3", 4'b1011, 8'h00);
        goto(61); lit("d3_blanked", 4'hF, 8'hFF);

        goto(73); lit("pre_reset_d2", 4'b1011, 8'h00);
        #1 reset = 1'b1;
        #1 lit("async_reset", 4'hF, 8'hFF);
        lit_fs("async_reset_fs", 1'b0);
        @(negedge clk);
        set_in(16'h1234, 4'b0000, 4'b0000);
        reset = 1'b0;
        goto(1);  load = 1'b0;
        goto(2);  lit("restart_d0", 4'b1110, 8'h99);
        goto(4);  lit("restart_d0_hold", 4'b1110, 8'h99);
        goto(5);  lit("restart_d1", 4'b1101, 8'hB0);

        set_in(16'h0050, 4'b0000, 4'b0000);
        goto(6);  load = 1'b0;
        goto(8);  lit("d1_0050", 4'b1101, 8'h92);
`ifdef SSEG_LZ_SUPPRESS_EN
        goto(9);  lit("d2_0050_lz", 4'hF, 8'hFF);
        goto(13); lit("d3_0050_lz", 4'hF, 8'hFF);
`else
        goto(9);  lit("d2_0050", 4'b1011, 8'hC0);
        goto(13); lit("d3_0050", 4'b0111, 8'hC0);
`endif
        goto(17); lit("d0_0050", 4'b1110, 8'hC0);
        goto(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/hex_sseg_mux.md
HEX_SSEG_MUX -- requirements
Module: hex_sseg_mux

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 SHALL have parameter PRESC_W, default 18, prescaler width; each digit is held for 2^PRESC_W clocks.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous active-high reset.
REQ-005 load  in  1  when high at a clk edge, capture hex_in/dp_in/blank_in into shadow registers.
REQ-006 hex_in  in  4*N_DIGITS  digit nibbles; digit i = hex_in[4i+3:4i], digit 0 rightmost.
REQ-007 dp_in  in  N_DIGITS  decimal point request per digit, 1 = lit.
REQ-008 blank_in  in  N_DIGITS  per-digit blank, 1 = digit dark.
REQ-009 an  out  N_DIGITS  anode enables, active low, registered.
REQ-010 sseg  out  8  cathodes, active low, registered; bit0..6 = segments a..g, bit7 = dp.
REQ-011 frame_start  out  1  one-cycle pulse when the scan index wraps to digit 0.

Function
REQ-012 Prescaler cnt (PRESC_W bits) SHALL increment every clock, wrapping all-ones -> 0; tick = (cnt == all-ones).
REQ-013 On tick, scan index idx SHALL advance by 1, wrapping N_DIGITS-1 -> 0; N_DIGITS = 1 holds idx at 0.
REQ-014 frame_start SHALL be high for exactly the one cycle following the edge at which idx wraps to 0.
REQ-015 an and sseg SHALL be registered from current idx and shadow registers: one-cycle latency after an idx change or shadow update.
REQ-016 For the selected non-blank digit, an SHALL have only bit idx low; sseg[6:0] SHALL be the inverse of active-high pattern 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-017 sseg[7] SHALL be ~dp shadow bit of the selected digit.
REQ-018 For a blanked selected digit, an SHALL be all ones and sseg SHALL be 8'hFF.
REQ-019 Shadow registers SHALL change only on load; inputs between loads SHALL not affect outputs.
REQ-020 load coincident with tick SHALL capture new data and advance idx on the same edge; the next output register update uses new data at the new idx.
REQ-021 Every hex value 0..F SHALL decode; no undefined output state.

Reset
REQ-022 While reset is high, asynchronously: cnt=0, idx=0, frame_start=0, an=all ones, sseg=8'hFF.
REQ-023 Reset SHALL set shadow hex=0, dp=0, blank=all ones (display dark until first load).
REQ-024 Reset asserted mid-scan SHALL abandon the frame; after release the scan restarts at digit 0 with a full 2^PRESC_W hold.

Configuration
REQ-025 Macro SSEG_LZ_SUPPRESS_EN: when defined, digits that are zero and have only zero digits above them (scanning from digit N_DIGITS-1 down) SHALL be treated as blanked per REQ-018; digit 0 is never suppressed.
REQ-026 Suppressed digits SHALL stay dark even if their dp bit is set.
REQ-027 When SSEG_LZ_SUPPRESS_EN is undefined, zero digits SHALL display "0" (sseg=8'hC0 with dp off) and suppression logic SHALL be absent.

Verification (N_DIGITS=4, PRESC_W=2)
REQ-028 Reset, load hex_in=16'h1234, blank=0, dp=0 -> per slot an/sseg: 1110/99, 1101/B0, 1011/A4, 0111/F9.
REQ-029 Free run after load -> each digit held 4 cycles, frame_start pulses every 16 cycles, exactly one cycle wide.
REQ-030 Load hex_in=16'h8888, dp_in=4'b0100 -> digit 2 slot sseg=8'h00, other slots sseg=8'h80.
REQ-031 Load blank_in=4'b1000 -> digit 3 slot an=4'b1111, sseg=8'hFF; digits 0..2 unaffected.
REQ-032 Assert reset while idx=2 -> same-cycle an=4'b1111, sseg=8'hFF; after release first lit slot is digit 0, held 4 cycles.
REQ-033 Load hex_in=16'h0050: with SSEG_LZ_SUPPRESS_EN digits 3,2 dark, digit1 sseg=92, digit0 sseg=C0; without it digits 3,2 show C0.
